// File: rtl/pc_sequencer_if.sv
// ============================================================================
//  Module   : pc_sequencer_if
//  Purpose  : Op/target input bundle and registered address outputs of
//             pc_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
    parameter int ADDR_WIDTH  = 20,
    parameter int STACK_DEPTH = 4
);
    localparam int LVL_WIDTH = $clog2(STACK_DEPTH) + 1;

    logic                  op_valid;
    logic [2:0]            op;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  stall;
    logic                  resume;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pc_valid;
    logic [1:0]            state;
    logic [LVL_WIDTH-1:0]  stack_level;
    logic                  err_overflow;
    logic                  err_underflow;

    modport master (
        output op_valid, op, target, offset, stall, resume,
        input  pc, pc_valid, state, stack_level, err_overflow, err_underflow
    );

    modport slave (
        input  op_valid, op, target, offset, stall, resume,
        output pc, pc_valid, state, stack_level, err_overflow, err_underflow
    );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Program counter feeding the 20-bit address decoder: INC, JUMP,
//             BRANCH, CALL/RET (return stack when PC_STACK_EN is defined), HALT.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int                    ADDR_WIDTH  = 20,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
    parameter int                    STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    localparam int LVL_WIDTH = $clog2(STACK_DEPTH) + 1;

    localparam logic [2:0] c_op_inc    = 3'd0;
    localparam logic [2:0] c_op_jump   = 3'd1;
    localparam logic [2:0] c_op_branch = 3'd2;
    localparam logic [2:0] c_op_call   = 3'd3;
    localparam logic [2:0] c_op_ret    = 3'd4;
    localparam logic [2:0] c_op_halt   = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
    logic                  r_pc_valid;
    logic                  r_unf, w_unf_next;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + ADDR_WIDTH'(1);

`ifdef PC_STACK_EN
    localparam int PTR_WIDTH = $clog2(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [LVL_WIDTH-1:0]  r_level, w_level_next;
    logic                  r_ovf, w_ovf_next;
    logic                  w_push;
    logic                  w_full, w_empty;
    logic [PTR_WIDTH-1:0]  w_wr_ptr, w_rd_ptr;

    assign w_full   = (r_level == LVL_WIDTH'(STACK_DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_wr_ptr = r_level[PTR_WIDTH-1:0];
    assign w_rd_ptr = w_wr_ptr - PTR_WIDTH'(1);

    // Stack storage is not reset; only the level says which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_wr_ptr] <= w_pc_inc;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_unf_next   = r_unf;
`ifdef PC_STACK_EN
        w_ovf_next   = r_ovf;
        w_level_next = r_level;
        w_push       = 1'b0;
`endif
        if (!bus.stall) begin
            case (r_state)
                ST_RUN: begin
                    if (bus.op_valid) begin
                        case (bus.op)
                            c_op_inc:    w_pc_next = w_pc_inc;
                            c_op_jump:   w_pc_next = bus.target;
                            c_op_branch: w_pc_next = r_pc + bus.offset;
                            c_op_call: begin
`ifdef PC_STACK_EN
                                if (w_full) begin
                                    w_ovf_next   = 1'b1;
                                    w_state_next = ST_FAULT;
                                end else begin
                                    w_push       = 1'b1;
                                    w_pc_next    = bus.target;
                                    w_level_next = r_level + LVL_WIDTH'(1);
                                end
`else
                                w_pc_next = bus.target;
`endif
                            end
                            c_op_ret: begin
`ifdef PC_STACK_EN
                                if (w_empty) begin
                                    w_unf_next   = 1'b1;
                                    w_state_next = ST_FAULT;
                                end else begin
                                    w_pc_next    = r_stack[w_rd_ptr];
                                    w_level_next = r_level - LVL_WIDTH'(1);
                                end
`else
                                w_unf_next   = 1'b1;
                                w_state_next = ST_FAULT;
`endif
                            end
                            c_op_halt:   w_state_next = ST_HALT;
                            default: begin
                                w_unf_next   = 1'b1;
                                w_state_next = ST_FAULT;
                            end
                        endcase
                    end
                end
                ST_HALT, ST_FAULT: begin
                    if (bus.resume) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: w_state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_ADDR;
            r_pc_valid <= 1'b0;
            r_unf      <= 1'b0;
`ifdef PC_STACK_EN
            r_ovf      <= 1'b0;
            r_level    <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_pc_valid <= 1'b1;
            r_unf      <= w_unf_next;
`ifdef PC_STACK_EN
            r_ovf      <= w_ovf_next;
            r_level    <= w_level_next;
`endif
        end
    end

    assign bus.pc            = r_pc;
    assign bus.pc_valid      = r_pc_valid;
    assign bus.state         = r_state;
    assign bus.err_underflow = r_unf;
`ifdef PC_STACK_EN
    assign bus.stack_level   = r_level;
    assign bus.err_overflow  = r_ovf;
`else
    assign bus.stack_level   = {LVL_WIDTH{1'b0}};
    assign bus.err_overflow  = 1'b0;
`endif

endmodule

`default_nettype wire
